conv_systolic_param: RTL and testbench
======================================

# conv_systolic_param

Parametrised systolic convolution engine: valid (no-padding) 2-D convolution of an IN_DIM×IN_DIM unsigned image with a K_DIM×K_DIM unsigned filter, using N_PE parallel multiply-accumulate PEs. It replaces the fixed 4×4/3×3 one/two/three-PE systolic variants with a single block configurable in width, size and PE count. Operands arrive through a load port instead of flat per-element ports. Control is a start/done handshake, and results stream out over a valid/ready interface.

## Interface
- DATA_W, 8, element width of image, filter and output data
- IN_DIM, 4, image side length; must be greater than or equal to K_DIM
- K_DIM, 3, filter side length
- N_PE, 2, number of output pixels computed in parallel; must divide OUT_DIM²
- SAT, 0, output narrowing mode: 0 keeps the low DATA_W bits (wrap), 1 saturates unsigned to 2^DATA_W−1
- Derived values: OUT_DIM = IN_DIM−K_DIM+1; ACC_W = 2·DATA_W + clog2(K_DIM²)
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- ld_en  in  1  write strobe for the operand memories
- ld_sel  in  1  target memory: 0 = image, 1 = filter
- ld_addr  in  clog2(IN_DIM²)  row-major element index
- ld_data  in  DATA_W  element value
- start  in  1  begin a convolution; sampled in IDLE only
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last result has been accepted
- out_valid  out  1  out_data and out_idx are valid
- out_ready  in  1  consumer accepts the current result
- out_data  out  DATA_W  narrowed output pixel
- out_idx  out  clog2(OUT_DIM²)  row-major output pixel index

## Operation
- Memories:
  - Image RAM holds IN_DIM² words; filter RAM holds K_DIM² words.
  - A write takes effect when ld_en=1 and busy=0.
  - Writes while busy, and filter writes with ld_addr ≥ K_DIM², are ignored.
- FSM states: IDLE, COMPUTE, DRAIN, DONE.
- IDLE → COMPUTE on start=1.
  - Group counter g is cleared, tap counter t is cleared, and all accumulators are cleared.
- COMPUTE, one tap per cycle, t = 0..K_DIM²−1:
  - ky = t / K_DIM, kx = t % K_DIM.
  - PE p owns output o = g·N_PE+p, at row r = o / OUT_DIM, column c = o % OUT_DIM.
  - Each cycle, PE p does acc_p += img[r+ky][c+kx] · filt[ky][kx], unsigned, ACC_W bits, no overflow possible.
  - After tap K_DIM²−1 is accumulated, go to DRAIN with drain index d = 0.
- DRAIN:
  - out_valid=1, out_data = narrow(acc_d), out_idx = g·N_PE+d.
  - On a handshake (out_valid & out_ready), d increments.
  - After the handshake at d = N_PE−1: if g is the last group, go to DONE; otherwise increment g, clear t and the accumulators, and go to COMPUTE.
- DONE: done=1 for exactly one cycle, then IDLE.
- start while busy is ignored. Memory contents persist across runs, so re-running without reloading reproduces the same results.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE; busy=0, done=0, out_valid=0, out_data=0, out_idx=0.
  - Counters, accumulators and both memories are cleared to 0.
- Reset asserted mid-run aborts the run; no done pulse is produced.
- The multiply-accumulate is single-cycle, so COMPUTE lasts exactly K_DIM² cycles per group.
- Output timing:
  - out_valid rises in the cycle after the last tap edge.
  - With out_ready held high, one result is accepted per cycle.
  - With out_ready low, out_valid, out_data and out_idx hold stable.
- Total run with no backpressure:
  - groups G = OUT_DIM²/N_PE.
  - Busy for G·(K_DIM²+N_PE)+1 cycles; done is high in the last of these.
  - Example, defaults: start sampled at edge E0; results accepted at E10, E11, E21, E22; done high between E22 and E23; IDLE from E23.
- out_valid is never high outside DRAIN.
- done and out_valid are never high in the same cycle.

## Test plan
- Base case, defaults:
  - Stimulus: load image 9,8,2,6 / 0,4,1,6 / 4,10,1,1 / 2,2,9,9 and filter 3,2,0 / 2,0,1 / 3,1,1; start; out_ready=1.
  - Required: results (idx,data) = (0,67), (1,74), (2,34), (3,59); done one cycle after the 4th handshake; busy for 23 cycles.
- PE-count sweep:
  - Stimulus: same data with N_PE=1 and with N_PE=4.
  - Required: identical results; busy 41 and 14 cycles respectively.
- Backpressure:
  - Stimulus: base case with out_ready=0 for 5 cycles after out_valid first rises.
  - Required: out_data=67 and out_idx=0 held stable; no result lost or repeated; done delayed by 5 cycles.
- Narrowing:
  - Stimulus: all image and filter elements = 255.
  - Required: every output = 9 with SAT=0, and every output = 255 with SAT=1.
- Reset and guards:
  - Stimulus: rst pulsed mid-COMPUTE.
  - Required: all outputs 0 immediately; no done pulse; memories read back 0 on the next run.
  - Stimulus: ld_en or start asserted while busy.
  - Required: no effect on memories or on the current run.

Source files
------------

// File: rtl/conv_systolic_param.sv
// conv_systolic_param: valid 2-D convolution with N_PE parallel MAC lanes,
// operands written through a load port, results streamed over valid/ready.
module conv_systolic_param #(
   parameter int DATA_W = 8,
   parameter int IN_DIM = 4,
   parameter int K_DIM  = 3,
   parameter int N_PE   = 2,
   parameter int SAT    = 0,
   localparam int OUT_DIM = IN_DIM - K_DIM + 1,
   localparam int AW = $clog2(IN_DIM * IN_DIM),
   localparam int OW = OUT_DIM > 1 ? $clog2(OUT_DIM * OUT_DIM) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld_en,
   input  logic              ld_sel,
   input  logic [AW-1:0]     ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [OW-1:0]     out_idx
);
   localparam int NT = K_DIM * K_DIM;
   localparam int NI = IN_DIM * IN_DIM;
   localparam int G = OUT_DIM * OUT_DIM / N_PE;
   localparam int ACC_W = 2 * DATA_W + $clog2(NT);
   localparam int TW = NT > 1 ? $clog2(NT) : 1;
   localparam int GW = G > 1 ? $clog2(G) : 1;
   localparam int DW = N_PE > 1 ? $clog2(N_PE) : 1;

   typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN, DONE} state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] img_q [NI];
   logic [DATA_W-1:0] img_d [NI];
   logic [DATA_W-1:0] filt_q [NT];
   logic [DATA_W-1:0] filt_d [NT];
   logic [ACC_W-1:0]  acc_q [N_PE];
   logic [ACC_W-1:0]  acc_d [N_PE];
   logic [ACC_W-1:0]  mac [N_PE];
   logic [TW-1:0]     t_q, t_d;
   logic [GW-1:0]     g_q, g_d;
   logic [DW-1:0]     d_q, d_d;
   logic [ACC_W-1:0]  acc_sel;

   // image element feeding output o at tap t
   function automatic int pix_idx(input int o, input int t);
      return (o / OUT_DIM + t / K_DIM) * IN_DIM + o % OUT_DIM + t % K_DIM;
   endfunction

   always_comb begin
      for (int p = 0; p < N_PE; p++)
         mac[p] = acc_q[p] + ACC_W'(img_q[AW'(pix_idx(int'(g_q) * N_PE + p, int'(t_q)))])
                           * ACC_W'(filt_q[t_q]);
   end

   always_comb begin
      state_d = state_q;
      t_d = t_q;
      g_d = g_q;
      d_d = d_q;
      img_d = img_q;
      filt_d = filt_q;
      acc_d = acc_q;
      if (ld_en && state_q == IDLE) begin
         if (!ld_sel) img_d[ld_addr] = ld_data;
         else if (int'(ld_addr) < NT) filt_d[TW'(ld_addr)] = ld_data;
      end
      unique case (state_q)
         IDLE: if (start) begin
            state_d = COMPUTE;
            t_d = '0;
            g_d = '0;
            d_d = '0;
            acc_d = '{default: '0};
         end
         COMPUTE: begin
            acc_d = mac;
            if (t_q == TW'(NT - 1)) begin
               state_d = DRAIN;
               d_d = '0;
            end else t_d = t_q + TW'(1);
         end
         DRAIN: if (out_ready) begin
            if (d_q != DW'(N_PE - 1)) d_d = d_q + DW'(1);
            else if (g_q == GW'(G - 1)) state_d = DONE;
            else begin
               state_d = COMPUTE;
               g_d = g_q + GW'(1);
               t_d = '0;
               acc_d = '{default: '0};
            end
         end
         DONE: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         t_q <= '0;
         g_q <= '0;
         d_q <= '0;
         img_q <= '{default: '0};
         filt_q <= '{default: '0};
         acc_q <= '{default: '0};
      end else begin
         state_q <= state_d;
         t_q <= t_d;
         g_q <= g_d;
         d_q <= d_d;
         img_q <= img_d;
         filt_q <= filt_d;
         acc_q <= acc_d;
      end
   end

   assign busy = state_q != IDLE;
   assign done = state_q == DONE;
   assign out_valid = state_q == DRAIN;
   assign acc_sel = acc_q[d_q];
   // saturate only when any bit above the output width is set
   assign out_data = !out_valid ? '0
                   : (SAT != 0 && |acc_sel[ACC_W-1:DATA_W]) ? '1 : acc_sel[DATA_W-1:0];
   assign out_idx = out_valid ? OW'(int'(g_q) * N_PE + int'(d_q)) : '0;
endmodule

// File: tb/tb_conv_systolic_param.sv
// tb_conv_systolic_param: four configurations driven in parallel and checked
// against a direct convolution model plus cycle-count rules.
module tb_conv_systolic_param;
   localparam int NPE_T [4] = '{2, 1, 4, 2};
   localparam int SAT_T [4] = '{0, 0, 0, 1};

   logic clk = 0, rst = 1, ld_en = 0, ld_sel = 0, start = 0, out_ready = 1;
   logic [3:0] ld_addr = 0;
   logic [7:0] ld_data = 0;
   logic busy [4], done [4], ov [4];
   logic [7:0] od [4];
   logic [1:0] oi [4];

   always #5 clk = ~clk;

   for (genvar k = 0; k < 4; k++) begin : g_dut
      conv_systolic_param #(.N_PE(NPE_T[k]), .SAT(SAT_T[k])) u_dut (
         .clk(clk), .rst(rst), .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr),
         .ld_data(ld_data), .start(start), .busy(busy[k]), .done(done[k]),
         .out_valid(ov[k]), .out_ready(out_ready), .out_data(od[k]), .out_idx(oi[k]));
   end

   logic [7:0] m_img [16];
   logic [7:0] m_filt [9];
   logic [7:0] expv [4][4];
   int exp_busy [4], nxt [4], bc [4], dn [4], last_hs [4];
   bit pv [4];
   logic [7:0] pd [4];
   logic [1:0] pi [4];
   bit pready;
   int cyc = 0, cmp_n = 0, fail_n = 0;

   function automatic logic [7:0] ref_px(input int o, input bit sat);
      int s;
      s = 0;
      for (int ky = 0; ky < 3; ky++)
         for (int kx = 0; kx < 3; kx++)
            s += int'(m_img[(o / 2 + ky) * 4 + o % 2 + kx]) * int'(m_filt[ky * 3 + kx]);
      if (sat && s > 255) return 8'hff;
      return s[7:0];
   endfunction

   task automatic chk(input bit ok, input string nm, input int act, input int req);
      cmp_n++;
      if (!ok) begin
         fail_n++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic check_cycle();
      cyc++;
      if (rst) begin
         for (int j = 0; j < 4; j++) pv[j] = 0;
         return;
      end
      for (int j = 0; j < 4; j++) begin
         if (busy[j]) bc[j]++;
         if (ov[j] || done[j]) chk(!(ov[j] && done[j]), "valid_done_excl", 1, 0);
         if (pv[j] && !pready) begin
            chk(ov[j] == 1'b1, "hold_valid", int'(ov[j]), 1);
            chk(od[j] == pd[j] && oi[j] == pi[j], "hold_data", int'(od[j]), int'(pd[j]));
         end
         if (ov[j] && out_ready) begin
            chk(nxt[j] < 4, "result_count", nxt[j] + 1, 4);
            if (nxt[j] < 4) begin
               chk(int'(oi[j]) == nxt[j], "out_idx", int'(oi[j]), nxt[j]);
               chk(od[j] == expv[j][nxt[j]], "out_data", int'(od[j]), int'(expv[j][nxt[j]]));
            end
            nxt[j]++;
            last_hs[j] = cyc;
         end
         if (done[j]) begin
            dn[j]++;
            chk(nxt[j] == 4, "done_all_accepted", nxt[j], 4);
            chk(last_hs[j] == cyc - 1, "done_timing", cyc - last_hs[j], 1);
            if (exp_busy[j] > 0) chk(bc[j] == exp_busy[j], "busy_len", bc[j], exp_busy[j]);
         end
         pv[j] = ov[j];
         pd[j] = od[j];
         pi[j] = oi[j];
      end
      pready = out_ready;
   endtask

   task automatic tick();
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input bit sel, input int addr, input logic [7:0] data);
      ld_en = 1;
      ld_sel = sel;
      ld_addr = 4'(addr);
      ld_data = data;
      tick();
      ld_en = 0;
      if (!sel) m_img[addr] = data;
      else if (addr < 9) m_filt[addr] = data;
   endtask

   // mode 0: ready high, 1: 5-cycle stall on first valid, 2: random ready,
   // 3: ready high with writes and start issued while busy
   task automatic run(input int mode, input bit chk_len);
      int n, stall;
      bit all_done;
      for (int j = 0; j < 4; j++) begin
         for (int o = 0; o < 4; o++) expv[j][o] = ref_px(o, SAT_T[j] != 0);
         exp_busy[j] = chk_len ? (4 / NPE_T[j]) * (9 + NPE_T[j]) + 1 + (mode == 1 ? 5 : 0) : 0;
         nxt[j] = 0;
         bc[j] = 0;
         dn[j] = 0;
         last_hs[j] = -10;
         pv[j] = 0;
      end
      start = 1;
      tick();
      start = 0;
      stall = 5;
      n = 0;
      all_done = 0;
      while (n < 400 && !all_done) begin
         out_ready = mode == 2 ? ($urandom_range(0, 2) != 0) : !(mode == 1 && ov[0] && stall > 0);
         if (mode == 1 && ov[0] && stall > 0) stall--;
         if (mode == 3) begin
            ld_en = busy[0] & busy[1] & busy[2] & busy[3];
            start = ld_en;
            ld_sel = 1'($urandom_range(0, 1));
            ld_addr = 4'($urandom_range(0, 15));
            ld_data = 8'($urandom);
         end
         tick();
         n++;
         all_done = 1;
         for (int j = 0; j < 4; j++) if (dn[j] == 0 || busy[j]) all_done = 0;
      end
      ld_en = 0;
      start = 0;
      out_ready = 1;
      for (int j = 0; j < 4; j++) begin
         chk(dn[j] == 1, "done_pulses", dn[j], 1);
         chk(nxt[j] == 4, "results_accepted", nxt[j], 4);
      end
   endtask

   task automatic load_all(input int maxv, input int fixed);
      for (int i = 0; i < 16; i++) load(0, i, 8'(fixed >= 0 ? fixed : $urandom_range(0, maxv)));
      for (int i = 0; i < 9; i++) load(1, i, 8'(fixed >= 0 ? fixed : $urandom_range(0, maxv)));
   endtask

   task automatic check_zero_outputs(input string nm);
      for (int j = 0; j < 4; j++) begin
         chk(!busy[j] && !done[j] && !ov[j], {nm, "_flags"},
             int'({busy[j], done[j], ov[j]}), 0);
         chk(od[j] == 0 && oi[j] == 0, {nm, "_data"}, int'({oi[j], od[j]}), 0);
      end
   endtask

   initial begin
      logic [7:0] base_img [16];
      logic [7:0] base_filt [9];
      base_img = '{9, 8, 2, 6, 0, 4, 1, 6, 4, 10, 1, 1, 2, 2, 9, 9};
      base_filt = '{3, 2, 0, 2, 0, 1, 3, 1, 1};
      for (int i = 0; i < 16; i++) m_img[i] = 0;
      for (int i = 0; i < 9; i++) m_filt[i] = 0;
      #1;
      check_zero_outputs("reset");
      #20;
      @(posedge clk);
      #1;
      rst = 0;
      for (int i = 0; i < 16; i++) load(0, i, base_img[i]);
      for (int i = 0; i < 9; i++) load(1, i, base_filt[i]);
      load(1, 12, 8'd77);
      chk(ref_px(0, 0) == 8'd67, "pin_o0", int'(ref_px(0, 0)), 67);
      chk(ref_px(1, 0) == 8'd74, "pin_o1", int'(ref_px(1, 0)), 74);
      chk(ref_px(2, 0) == 8'd34, "pin_o2", int'(ref_px(2, 0)), 34);
      chk(ref_px(3, 0) == 8'd59, "pin_o3", int'(ref_px(3, 0)), 59);
      run(0, 1);
      run(0, 1);
      run(1, 1);
      run(3, 1);
      run(0, 1);
      load_all(255, 255);
      chk(ref_px(2, 0) == 8'd9, "pin_wrap", int'(ref_px(2, 0)), 9);
      chk(ref_px(2, 1) == 8'd255, "pin_sat", int'(ref_px(2, 1)), 255);
      run(0, 1);
      for (int r = 0; r < 4; r++) begin
         load_all(r == 0 ? 255 : r == 1 ? 15 : 60, -1);
         run(2, 0);
      end
      load_all(255, -1);
      start = 1;
      tick();
      start = 0;
      repeat (4) tick();
      rst = 1;
      #1;
      check_zero_outputs("abort");
      for (int i = 0; i < 16; i++) m_img[i] = 0;
      for (int i = 0; i < 9; i++) m_filt[i] = 0;
      tick();
      rst = 0;
      repeat (30) begin
         tick();
         for (int j = 0; j < 4; j++) chk(!done[j] && !busy[j], "idle_after_abort", int'({done[j], busy[j]}), 0);
      end
      run(0, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
      $finish;
   end
endmodule
